// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types and ADS1115 helpers for the ADC scan controller
// Contents: scan FSM state enum, ADC register pointer constants, and the
// config high-byte builder used for each single-shot conversion request.
package adc_scan_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG_START,
    CFG_WAIT,
    CONV_WAIT,
    PTR_START,
    PTR_WAIT,
    RD_START,
    RD_WAIT,
    PUBLISH
  } state_t;

  localparam logic [7:0] REG_CONV = 8'h00;
  localparam logic [7:0] REG_CFG  = 8'h01;

  // {OS=1, MUX=1xx (single-ended AINx vs GND), PGA, MODE=1 (single-shot)}
  function automatic logic [7:0] cfg_msb(input logic [1:0] ch, input logic [2:0] pga);
    return {1'b1, 1'b1, ch, pga, 1'b1};
  endfunction

endpackage

// File: rtl/adc_scan_controller_if.sv
// rtl/adc_scan_controller_if.sv - request/response bundle between the scan controller and i2c_master
// master modport (scan controller): drives i2c_start, i2c_rd_nwr, i2c_slave_addr,
//   i2c_din, i2c_bytes_num; receives i2c_dout, i2c_done.
// slave modport (i2c_master side): the mirror image.
// Byte [0] of i2c_din / i2c_dout is the first byte on the wire.
interface adc_scan_controller_if #(
  parameter int MAX_BYTES = 3
);
  localparam int BNW = $clog2(MAX_BYTES + 1);

  logic                      i2c_start;
  logic                      i2c_rd_nwr;
  logic [6:0]                i2c_slave_addr;
  logic [MAX_BYTES-1:0][7:0] i2c_din;
  logic [BNW-1:0]            i2c_bytes_num;
  logic [MAX_BYTES-1:0][7:0] i2c_dout;
  logic                      i2c_done;

  modport master (
    output i2c_start, i2c_rd_nwr, i2c_slave_addr, i2c_din, i2c_bytes_num,
    input  i2c_dout, i2c_done
  );

  modport slave (
    input  i2c_start, i2c_rd_nwr, i2c_slave_addr, i2c_din, i2c_bytes_num,
    output i2c_dout, i2c_done
  );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - clearable up-counter with terminal-count flag
// Ports: clk, reset (sync, active-low), clear (zero the count, wins over en),
//   en (count up), limit (terminal value), tc (count == limit).
module cycle_timer #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/adc_scan_controller.sv
// rtl/adc_scan_controller.sv - sequences i2c_master to scan an ADS1115-style 4-channel ADC
// Ports: clk, reset (sync, active-low), enable (level, keep scanning),
//   bus (master side of the i2c_master request/response bundle),
//   sample/sample_ch (last result and its channel), sample_valid (pulse),
//   scan_done (pulse with the last channel's sample_valid), busy (not idle),
//   timeout_err (sticky until reset).
// Per channel: config write (single-shot), conversion wait, pointer write, 2-byte read.
module adc_scan_controller
  import adc_scan_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR                = 7'h48,
  parameter int         NUM_CHANNELS              = 4,
  parameter int         MAX_BYTES_PER_TRANSACTION = 3,
  parameter logic [2:0] PGA_BITS                  = 3'b001,
  parameter logic [7:0] CFG_LSB                   = 8'hE3,
  parameter int         CONV_WAIT_CYCLES          = 150000,
  parameter int         TIMEOUT_CYCLES            = 2000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  adc_scan_controller_if.master        bus,
  output logic [15:0]                  sample,
  output logic [1:0]                   sample_ch,
  output logic                         sample_valid,
  output logic                         scan_done,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int BNW  = $clog2(MAX_BYTES_PER_TRANSACTION + 1);
  localparam int TMAX = (CONV_WAIT_CYCLES > TIMEOUT_CYCLES) ? CONV_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [1:0] LAST_CH = 2'(NUM_CHANNELS - 1);

  state_t          state, state_next;
  logic [1:0]      ch;
  logic            waiting;
  logic            timeout_hit;
  logic            timer_en;
  logic            timer_clear;
  logic            timer_tc;
  logic [TW-1:0]   timer_limit;
  logic            unused_dout;

  assign waiting     = (state == CFG_WAIT) || (state == PTR_WAIT) || (state == RD_WAIT);
  assign timeout_hit = waiting && !bus.i2c_done && timer_tc;

  // One timer serves both the conversion wait and the transaction watchdog;
  // every state change restarts it from zero.
  assign timer_en    = waiting || (state == CONV_WAIT);
  assign timer_clear = (state_next != state);
  assign timer_limit = (state == CONV_WAIT) ? TW'(CONV_WAIT_CYCLES - 1)
                                            : TW'(TIMEOUT_CYCLES - 1);

  // Third read byte is never requested.
  assign unused_dout = ^bus.i2c_dout[MAX_BYTES_PER_TRANSACTION-1:2];

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (enable) state_next = CFG_START;
      CFG_START: state_next = CFG_WAIT;
      CFG_WAIT:  if (bus.i2c_done) state_next = CONV_WAIT;
                 else if (timeout_hit) state_next = IDLE;
      CONV_WAIT: if (timer_tc) state_next = PTR_START;
      PTR_START: state_next = PTR_WAIT;
      PTR_WAIT:  if (bus.i2c_done) state_next = RD_START;
                 else if (timeout_hit) state_next = IDLE;
      RD_START:  state_next = RD_WAIT;
      RD_WAIT:   if (bus.i2c_done) state_next = PUBLISH;
                 else if (timeout_hit) state_next = IDLE;
      PUBLISH:   state_next = enable ? CFG_START : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Request fields are decoded from the START/WAIT pair, so they stay put
  // from the start pulse through the done cycle.
  always_comb begin
    bus.i2c_start      = 1'b0;
    bus.i2c_rd_nwr     = 1'b0;
    bus.i2c_bytes_num  = '0;
    bus.i2c_din        = '0;
    bus.i2c_slave_addr = SLAVE_ADDR;
    busy               = (state != IDLE);
    case (state)
      CFG_START, CFG_WAIT: begin
        bus.i2c_start     = (state == CFG_START);
        bus.i2c_bytes_num = BNW'(3);
        bus.i2c_din[0]    = REG_CFG;
        bus.i2c_din[1]    = cfg_msb(ch, PGA_BITS);
        bus.i2c_din[2]    = CFG_LSB;
      end
      PTR_START, PTR_WAIT: begin
        bus.i2c_start     = (state == PTR_START);
        bus.i2c_bytes_num = BNW'(1);
        bus.i2c_din[0]    = REG_CONV;
      end
      RD_START, RD_WAIT: begin
        bus.i2c_start     = (state == RD_START);
        bus.i2c_rd_nwr    = 1'b1;
        bus.i2c_bytes_num = BNW'(2);
      end
      default: ;
    endcase
  end

  // Sample is captured on the read's done edge so sample_valid is high
  // during PUBLISH, one cycle after i2c_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ch           <= '0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      if (state == RD_WAIT && bus.i2c_done) begin
        sample       <= {bus.i2c_dout[0], bus.i2c_dout[1]};
        sample_ch    <= ch;
        sample_valid <= 1'b1;
        scan_done    <= (ch == LAST_CH);
      end
      if (state == PUBLISH) begin
        ch <= (ch == LAST_CH) ? 2'd0 : ch + 2'd1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// tb/tb_adc_scan_controller.sv - scoreboard bench for adc_scan_controller with a transaction-level I2C master/ADC model
module tb_adc_scan_controller;

  localparam int CW  = 200;
  localparam int TO  = 3000;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample;
  logic [1:0]  sample_ch;
  logic        sample_valid, scan_done, busy, timeout_err;

  always #5 clk = ~clk;

  adc_scan_controller_if #(.MAX_BYTES(3)) bus ();

  adc_scan_controller #(
    .SLAVE_ADDR(7'h48), .NUM_CHANNELS(NCH), .MAX_BYTES_PER_TRANSACTION(3),
    .PGA_BITS(3'b001), .CFG_LSB(8'hE3), .CONV_WAIT_CYCLES(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] val;
    logic [1:0]  ch;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          hang = 0;
  int          exp_ch = 0;
  int          phase = 0;          // 0 expect config write, 1 pointer write, 2 read
  int          fixed_left = 4;
  logic [15:0] fixed_val [NCH] = '{16'h1234, 16'h0ABC, 16'h7FFF, 16'h8000};
  logic [15:0] conv_reg [NCH];
  logic [15:0] cur_val = '0;
  int          cfg_done_cyc = 0;
  int          rd_done_cyc = -10;
  int          last_start_cyc = 0;
  int          n_start = 0;
  int          n_valid = 0;
  int          n_scan = 0;
  int          rd_start_ch = -1;
  int          ptr_start_ch = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level stand-in for i2c_master plus the ADC at 0x48.
  initial begin : i2c_model
    bit              pend;
    bit              bad;
    int              cd, kind, extra, sel;
    logic            rd;
    logic [1:0]      bn;
    logic [2:0][7:0] din;
    logic [7:0]      msb_exp;
    pend = 0; bad = 0; cd = 0; kind = 0; extra = 0; sel = 0;
    rd = 0; bn = '0; din = '0; msb_exp = '0;
    bus.i2c_done = 1'b0;
    bus.i2c_dout = '0;
    for (int i = 0; i < NCH; i++) conv_reg[i] = '0;
    forever begin
      @(negedge clk);
      bus.i2c_done = 1'b0;
      if (!reset) begin
        pend = 0; phase = 0; exp_ch = 0; sb.delete();
      end else if (pend && !busy) begin
        pend = 0; phase = 0;
      end else if (pend) begin
        if (bus.i2c_start) extra++;
        if (bus.i2c_rd_nwr !== rd || bus.i2c_bytes_num !== bn || bus.i2c_din !== din) bad = 1;
        if (!hang) begin
          if (cd > 0) begin
            cd--;
          end else begin
            pend = 0;
            bus.i2c_done = 1'b1;
            bus.i2c_dout = {8'($urandom), 8'($urandom), 8'($urandom)};
            chk("req_stable", 32'(bad), 32'd0);
            chk("one_start_per_txn", 32'(extra), 32'd0);
            case (kind)
              0: begin cfg_done_cyc = cyc; phase = 1; end
              1: phase = 2;
              default: begin
                bus.i2c_dout[0] = conv_reg[sel][15:8];
                bus.i2c_dout[1] = conv_reg[sel][7:0];
                sb.push_back('{val: cur_val, ch: 2'(exp_ch)});
                rd_done_cyc = cyc;
                exp_ch = (exp_ch + 1) % NCH;
                phase = 0;
              end
            endcase
          end
        end
      end else if (bus.i2c_start) begin
        n_start++;
        last_start_cyc = cyc;
        rd = bus.i2c_rd_nwr; bn = bus.i2c_bytes_num; din = bus.i2c_din;
        pend = 1; bad = 0; extra = 0;
        cd = $urandom_range(25, 2);
        chk("slave_addr", 32'(bus.i2c_slave_addr), 32'h48);
        kind = rd ? 2 : ((bn == 2'd3) ? 0 : 1);
        chk("txn_order", 32'(kind), 32'(phase));
        if (kind == 0) begin
          // single-ended mux 1xx, PGA 001, single-shot, OS set
          msb_exp = 8'(32'hC3 | (exp_ch << 4));
          chk("cfg_bytes", 32'(din), {8'h00, 8'hE3, msb_exp, 8'h01});
          sel = int'(din[1][5:4]);
          if (fixed_left > 0) begin
            cur_val = fixed_val[exp_ch];
            fixed_left--;
          end else begin
            cur_val = 16'($urandom);
          end
          conv_reg[sel] = cur_val;
        end else if (kind == 1) begin
          chk("ptr_bytes", 32'({bn, din}), {6'd0, 2'd1, 24'h000000});
          chk("conv_wait", 32'(cyc - cfg_done_cyc), 32'(CW + 1));
          ptr_start_ch = exp_ch;
        end else begin
          chk("rd_bytes_num", 32'(bn), 32'd2);
          rd_start_ch = exp_ch;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && sample_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          chk("unexpected_sample", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sample", 32'(sample), 32'(e.val));
          chk("sample_ch", 32'(sample_ch), 32'(e.ch));
          chk("scan_done", 32'(scan_done), 32'(e.ch == 2'(NCH - 1)));
          chk("valid_latency", 32'(cyc - rd_done_cyc), 32'd1);
        end
        if (scan_done) n_scan++;
      end
    end
  end

  function automatic bit cond(input int what, input int target);
    case (what)
      0: return n_valid >= target;
      1: return n_scan >= target;
      2: return rd_start_ch == target;
      3: return ptr_start_ch == target;
      4: return timeout_err === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int what, input int target, input int lim, input string nm);
    int n = 0;
    while (!cond(what, target) && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_reached"}, 32'(n < lim), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_i2c_start"}, 32'(bus.i2c_start), 32'd0);
    chk({tag, "_rd_nwr"}, 32'(bus.i2c_rd_nwr), 32'd0);
    chk({tag, "_bytes_num"}, 32'(bus.i2c_bytes_num), 32'd0);
    chk({tag, "_din"}, 32'(bus.i2c_din), 32'd0);
    chk({tag, "_slave_addr"}, 32'(bus.i2c_slave_addr), 32'h48);
    chk({tag, "_sample"}, 32'(sample), 32'd0);
    chk({tag, "_sample_ch"}, 32'(sample_ch), 32'd0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin : main
    int s0;
    reset = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("por");
    reset = 1'b1;
    @(negedge clk); #1;

    // full scan with the fixed sample table
    enable = 1'b1;
    wait_for(1, 1, 8 * CW, "scan1");
    enable = 1'b0;
    wait_for(5, 0, 10, "scan1_idle");
    chk("scan1_samples", 32'(n_valid), 32'd4);

    // drop enable while ch 1 read is in flight
    rd_start_ch = -1;
    enable = 1'b1;
    wait_for(2, 1, 6 * CW, "ch1_read");
    enable = 1'b0;
    s0 = n_valid;
    wait_for(0, s0 + 1, 100, "ch1_publish");
    wait_for(5, 0, 10, "ch1_idle");
    s0 = n_start;
    repeat (3 * CW) @(negedge clk);
    #1;
    chk("no_start_when_disabled", 32'(n_start), 32'(s0));
    chk("idle_busy", 32'(busy), 32'd0);

    // resume: config checks expect ch 2 next
    enable = 1'b1;
    wait_for(1, 2, 8 * CW, "resume_scan");
    enable = 1'b0;
    wait_for(5, 0, 10, "resume_idle");
    chk("resume_samples", 32'(n_valid), 32'd8);

    // random enable windows
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1;
      repeat ($urandom_range(1600, 50)) @(negedge clk);
      #1;
      enable = 1'b0;
      wait_for(5, 0, 4 * CW, "rand_idle");
    end

    // slave never completes
    hang = 1;
    enable = 1'b1;
    wait_for(4, 0, TO + 100, "timeout_flag");
    chk("timeout_latency", 32'(cyc - last_start_cyc), 32'(TO + 1));
    chk("timeout_idle", 32'(busy), 32'd0);
    enable = 1'b0;
    hang = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("timeout_stays_idle", 32'(busy), 32'd0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // retry of the same channel, then reset during ch 2 pointer wait
    s0 = n_valid;
    enable = 1'b1;
    wait_for(0, s0 + 1, 4 * CW, "retry_publish");
    ptr_start_ch = -1;
    wait_for(3, 2, 8 * CW, "ch2_ptr");
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk_reset("mid_ptr");
    reset = 1'b1;
    s0 = n_scan;
    wait_for(1, s0 + 1, 8 * CW, "post_reset_scan");
    enable = 1'b0;
    wait_for(5, 0, 10, "final_idle");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
